// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state encoding and full-subtractor bit equations shared by
// the serial subtractor RTL (optional signed overflow output: SERIAL_SUB_OVF_EN).
package serial_sub_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell, {bout, d} = a - b - bin.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign {bout, d} = fs_bit(a, b, bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             bor_q, d, bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, b_msb_q;
`endif
  full_subtractor u_fs (.a(a_q[0]), .b(b_q[0]), .bin(bor_q), .d(d), .bout(bout));
  // New bit enters at the MSB so the LSB-first result ends aligned after WIDTH steps.
  assign res_d = {d, res_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      bor_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q <= ST_SHIFT;
          a_q     <= a;
          b_q     <= b;
          bor_q   <= 1'b0;
          cnt_q   <= '0;
          busy    <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_q <= a[WIDTH-1];
          b_msb_q <= b[WIDTH-1];
`endif
        end
      end else begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        res_q <= res_d;
        bor_q <= bout;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_q    <= ST_IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
          diff       <= res_d;
          borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf        <= (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances).
module tb_serial_subtractor;
  typedef struct packed {logic [7:0] diff; logic bo; logic ov;} exp8_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start2 = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic [1:0] a2 = '0, b2 = '0, diff2;
  logic busy, done, borrow_out, busy2, done2, bo2;
  logic ovf, ovf2;
  exp8_t q8[$];
  logic [2:0] q2[$];
  int checks = 0, passes = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .busy(busy2), .done(done2),
    .diff(diff2), .borrow_out(bo2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf2)
`endif
  );
`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
  assign ovf2 = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y);
    int sd;
    exp8_t e;
    sd = int'($signed(x)) - int'($signed(y));
    e.diff = 8'(int'(x) - int'(y));
    e.bo = (int'(x) < int'(y));
`ifdef SERIAL_SUB_OVF_EN
    e.ov = (sd > 127) || (sd < -128);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic check_result(input string name);
    exp8_t e, got;
    e = q8.pop_front();
    got = '{diff, borrow_out, ovf};
    checks++;
    if (got !== e)
      $display("FAIL %s: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
               name, diff, borrow_out, ovf, e.diff, e.bo, e.ov);
    else passes++;
  endtask

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    q8.push_back(model8(x, y));
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string name);
    int n;
    accept(x, y);
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy: got %b expected 1", name, busy); else passes++;
    wait_done(n);
    checks++;
    if (n != 8) $display("FAIL %s latency: got %0d edges expected 8", name, n); else passes++;
    check_result(name);
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL %s done_drop: got done=%b busy=%b expected 0 0", name, done, busy);
    else passes++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, diff, borrow_out, ovf, busy2, done2, diff2, bo2} !== '0)
      $display("FAIL reset: got busy=%b done=%b diff=%h borrow=%b ovf=%b expected all 0", busy, done, diff, borrow_out, ovf);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(8'd5, 8'd3, "5-3");
    run_op(8'd3, 8'd5, "3-5");
    run_op(8'h80, 8'h01, "80-01");
    run_op(8'h00, 8'h00, "0-0");
    run_op(8'h7F, 8'hFF, "7F-FF");
    for (int i = 0; i < 4; i++) run_op(8'($urandom), 8'($urandom), "random");
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    accept(8'd9, 8'd4);
    for (int i = 1; i <= 14; i++) begin
      start = (i == 2 || i == 4);
      if (start) begin a = 8'd1; b = 8'd2; end
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) check_result("busy_ignore");
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 1) $display("FAIL busy_ignore pulses: got %0d expected 1", pulses); else passes++;
  endtask

  task automatic test_back_to_back();
    int n;
    exp8_t first;
    accept(8'h30, 8'h10);
    first = q8[0];
    wait_done(n);
    check_result("b2b_first");
    accept(8'h10, 8'h20);
    checks++;
    if ({done, busy, diff, borrow_out} !== {1'b0, 1'b1, first.diff, first.bo})
      $display("FAIL b2b_hold: got done=%b busy=%b diff=%h borrow=%b expected 0 1 %h %b",
               done, busy, diff, borrow_out, first.diff, first.bo);
    else passes++;
    wait_done(n);
    checks++;
    if (n != 8) $display("FAIL b2b latency: got %0d edges expected 8", n); else passes++;
    check_result("b2b_second");
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    run_op(8'h55, 8'h11, "pre_abort");
    accept(8'hC3, 8'h21);
    void'(q8.pop_back());
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, ovf} !== '0)
      $display("FAIL abort: got busy=%b done=%b diff=%h borrow=%b ovf=%b expected all 0", busy, done, diff, borrow_out, ovf);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); else passes++;
    run_op(8'd7, 8'd7, "7-7");
  endtask

  task automatic test_width2();
    int n;
    logic [2:0] e;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        q2.push_back({2'((x - y) & 3), 1'(x < y)});
        start2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
        @(posedge clk); #1;
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!done2 && n < 10);
        e = q2.pop_front();
        checks++;
        if (n != 2 || {diff2, bo2} !== e)
          $display("FAIL w2 %0d-%0d: got diff=%h borrow=%b after %0d edges expected diff=%h borrow=%b after 2",
                   x, y, diff2, bo2, n, e[2:1], e[0]);
        else passes++;
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_width2();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
